// File: rtl/fp_lzc_norm_pipe.sv
// Three-stage leading/trailing-bit counter with normalising shifter.
// Valid/ready handshake; a stall freezes every stage, flush kills in-flight work.
module fp_lzc_norm_pipe #(
  parameter int WIDTH = 64,
  parameter int SEG   = 8,
  parameter int TAG_W = 6,
  localparam int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_count,
  output logic             out_zero,
  output logic [WIDTH-1:0] out_norm,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NSEG = WIDTH / SEG;
  localparam int SCW  = $clog2(SEG) + 1;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  // stage 1: transformed word and per-segment counts (segment 0 is most significant)
  logic [WIDTH-1:0]           t;
  logic [NSEG-1:0][SCW-1:0]   seg_cnt;
  logic [NSEG-1:0]            seg_zero;

  always_comb begin
    t = in_data;
    if (in_mode == 2'b01) begin
      t = ~in_data;
    end else if (in_mode == 2'b10) begin
      for (int i = 0; i < WIDTH; i++) t[i] = in_data[WIDTH-1-i];
    end
  end

  always_comb begin
    for (int s = 0; s < NSEG; s++) begin
      seg_cnt[s]  = SCW'(SEG);
      seg_zero[s] = 1'b1;
      for (int b = 0; b < SEG; b++) begin
        if (t[WIDTH-SEG*(s+1)+b]) begin
          seg_cnt[s]  = SCW'(SEG - 1 - b);
          seg_zero[s] = 1'b0;
        end
      end
    end
  end

  logic                      s1_valid;
  logic [WIDTH-1:0]          s1_data;
  logic [1:0]                s1_mode;
  logic [TAG_W-1:0]          s1_tag;
  logic [NSEG-1:0][SCW-1:0]  s1_cnt;
  logic [NSEG-1:0]           s1_zero;

  // stage 2: first non-empty segment from the top wins
  logic [CNT_W-1:0] cnt2;

  always_comb begin
    cnt2 = CNT_W'(WIDTH);
    for (int s = NSEG - 1; s >= 0; s--) begin
      if (!s1_zero[s]) cnt2 = CNT_W'(s * SEG) + CNT_W'(s1_cnt[s]);
    end
  end

  logic              s2_valid;
  logic [WIDTH-1:0]  s2_data;
  logic [1:0]        s2_mode;
  logic [TAG_W-1:0]  s2_tag;
  logic [CNT_W-1:0]  s2_cnt;

  // stage 3: normalising shift; a full-width count yields zero
  logic [WIDTH-1:0] norm3;
  logic             zero3;

  always_comb begin
    zero3 = (s2_cnt == CNT_W'(WIDTH));
    if (zero3)                 norm3 = '0;
    else if (s2_mode == 2'b10) norm3 = s2_data >> s2_cnt;
    else                       norm3 = s2_data << s2_cnt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid  <= 1'b0;
      s2_valid  <= 1'b0;
      out_valid <= 1'b0;
      out_count <= '0;
      out_zero  <= 1'b0;
      out_norm  <= '0;
      out_tag   <= '0;
    end else begin
      if (flush) begin
        s1_valid  <= 1'b0;
        s2_valid  <= 1'b0;
        out_valid <= 1'b0;
      end else if (advance) begin
        s1_valid  <= in_valid;
        s2_valid  <= s1_valid;
        out_valid <= s2_valid;
      end
      if (advance) begin
        s1_data   <= in_data;
        s1_mode   <= in_mode;
        s1_tag    <= in_tag;
        s1_cnt    <= seg_cnt;
        s1_zero   <= seg_zero;
        s2_data   <= s1_data;
        s2_mode   <= s1_mode;
        s2_tag    <= s1_tag;
        s2_cnt    <= cnt2;
        out_count <= s2_cnt;
        out_zero  <= zero3;
        out_norm  <= norm3;
        out_tag   <= s2_tag;
      end
    end
  end

endmodule

// File: tb/tb_fp_lzc_norm_pipe.sv
// Scoreboard bench: three configurations run in lockstep from one stimulus stream,
// results checked against a bit-scanning reference model.
module tb_fp_lzc_norm_pipe;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b1;
  logic [63:0] in_data = '0;
  logic [1:0]  in_mode = '0;
  logic [5:0]  in_tag = '0;

  logic        rdy0, rdy1, rdy2, ov0, ov1, ov2, z0, z1, z2;
  logic [6:0]  cnt0, cnt2;
  logic [5:0]  cnt1;
  logic [63:0] n0, n2;
  logic [31:0] n1;
  logic [5:0]  tg0, tg1, tg2;

  fp_lzc_norm_pipe #(.WIDTH(64), .SEG(8), .TAG_W(6)) u0 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag), .out_valid(ov0),
    .out_ready(out_ready), .out_count(cnt0), .out_zero(z0), .out_norm(n0), .out_tag(tg0));

  fp_lzc_norm_pipe #(.WIDTH(32), .SEG(4), .TAG_W(6)) u1 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data[31:0]), .in_mode(in_mode), .in_tag(in_tag), .out_valid(ov1),
    .out_ready(out_ready), .out_count(cnt1), .out_zero(z1), .out_norm(n1), .out_tag(tg1));

  fp_lzc_norm_pipe #(.WIDTH(64), .SEG(16), .TAG_W(6)) u2 (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .in_mode(in_mode), .in_tag(in_tag), .out_valid(ov2),
    .out_ready(out_ready), .out_count(cnt2), .out_zero(z2), .out_norm(n2), .out_tag(tg2));

  always #5 clk = ~clk;

  typedef struct {
    logic [5:0]  tag;
    int          acc_cyc;
    int          acc_stall;
    int          c64;
    logic [63:0] n64;
    int          c32;
    logic [63:0] n32;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall = 0;
  logic rnd_ready = 1'b0;
  logic hold_prev = 1'b0;
  logic [6:0]  h_cnt;
  logic [63:0] h_norm;
  logic [5:0]  h_tag;
  logic        h_zero;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: scan bits of a w-bit operand directly, then shift the masked operand.
  function automatic void ref_model(input logic [63:0] d, input logic [1:0] m, input int w,
                                    output int cnt, output logic [63:0] norm);
    logic [63:0] mask;
    logic [63:0] dm;
    logic        b;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    dm   = d & mask;
    cnt  = 0;
    if (m == 2'b10) begin
      while (cnt < w && d[cnt] == 1'b0) cnt++;
    end else begin
      b = (m == 2'b01);
      while (cnt < w && d[w-1-cnt] == b) cnt++;
    end
    if (cnt >= w)        norm = '0;
    else if (m == 2'b10) norm = dm >> cnt;
    else                 norm = (dm << cnt) & mask;
  endfunction

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1;
    if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);
  end

  always @(negedge clk) begin
    exp_t e;
    chk("in_ready", rdy0, !(ov0 && !out_ready));
    if (hold_prev) begin
      chk("hold_valid", ov0, 1);
      chk("hold_count", cnt0, h_cnt);
      chk("hold_norm", n0, h_norm);
      chk("hold_tag", tg0, h_tag);
      chk("hold_zero", z0, h_zero);
    end
    if (!rst) begin
      chk("lockstep_valid1", ov1, ov0);
      chk("lockstep_valid2", ov2, ov0);
    end
    if (ov0 && out_ready && !rst) begin
      if (q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_output actual_tag=%0h required=none", tg0);
      end else begin
        e = q.pop_front();
        chk("latency", cyc, e.acc_cyc + 3 + (stall - e.acc_stall));
        chk("tag64s8", tg0, e.tag);
        chk("count64s8", cnt0, e.c64);
        chk("zero64s8", z0, e.c64 == 64);
        chk("norm64s8", n0, e.n64);
        chk("tag32s4", tg1, e.tag);
        chk("count32s4", cnt1, e.c32);
        chk("zero32s4", z1, e.c32 == 32);
        chk("norm32s4", n1, e.n32);
        chk("tag64s16", tg2, e.tag);
        chk("count64s16", cnt2, e.c64);
        chk("zero64s16", z2, e.c64 == 64);
        chk("norm64s16", n2, e.n64);
      end
    end
    if (rst || flush) begin
      q.delete();
    end else if (in_valid && rdy0) begin
      e.tag       = in_tag;
      e.acc_cyc   = cyc;
      e.acc_stall = stall;
      ref_model(in_data, in_mode, 64, e.c64, e.n64);
      ref_model(in_data, in_mode, 32, e.c32, e.n32);
      q.push_back(e);
    end
    if (ov0 && !out_ready) stall++;
    hold_prev = ov0 && !out_ready && !rst && !flush;
    h_cnt  = cnt0;
    h_norm = n0;
    h_tag  = tg0;
    h_zero = z0;
  end

  task automatic send(input logic [63:0] d, input logic [1:0] m, input logic [5:0] t);
    int n = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_mode  = m;
    in_tag   = t;
    @(negedge clk);
    while (!rdy0 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!rdy0) begin
      $display("FAIL send_timeout actual=in_ready_low required=in_ready_high");
      $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
      $fatal(1, "input stuck");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((q.size() != 0 || ov0) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    repeat (4) @(posedge clk);
    #1;
    chk("drain_pending", q.size(), 0);
    chk("drain_valid", ov0, 0);
  endtask

  task automatic run_vec(input logic [63:0] d, input logic [1:0] m, input logic [5:0] t,
                         input int ec, input logic [63:0] en, input logic ez, input string name);
    int n = 0;
    send(d, m, t);
    do begin
      @(negedge clk);
      n++;
    end while (!ov0 && n < 20);
    chk({name, "_valid"}, ov0, 1);
    chk({name, "_count"}, cnt0, ec);
    chk({name, "_norm"}, n0, en);
    chk({name, "_zero"}, z0, ez);
    chk({name, "_tag"}, tg0, t);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] gen_data();
    logic [63:0] x;
    int k;
    int k2;
    x  = {$urandom, $urandom};
    k  = $urandom_range(0, 64);
    k2 = $urandom_range(0, 32);
    case ($urandom_range(0, 7))
      0: return x;
      1: return x >> k;
      2: return x << k;
      3: return ~(x >> k);
      4: return ~(x << k);
      5: return {x[63:32], x[31:0] >> k2};
      6: return {x[63:32], ~(x[31:0] >> k2)};
      default: return {x[63:32], x[31:0] << k2};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks + 1, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("reset_valid", ov0, 0);
    chk("reset_count", cnt0, 0);
    chk("reset_zero", z0, 0);
    chk("reset_norm", n0, 0);
    chk("reset_tag", tg0, 0);
    chk("reset_in_ready", rdy0, 1);

    run_vec(64'h0000_0000_0001_0000, 2'b00, 6'd5, 47, 64'h8000_0000_0000_0000, 1'b0, "clz_single");
    run_vec(64'h0000_0000_0001_0000, 2'b11, 6'd6, 47, 64'h8000_0000_0000_0000, 1'b0, "mode11");
    run_vec(64'h0, 2'b00, 6'd7, 64, 64'h0, 1'b1, "clz_zero");
    run_vec(64'hFFFF_FFFF_FFFF_FFFF, 2'b01, 6'd8, 64, 64'h0, 1'b1, "clo_ones");
    run_vec(64'hFFF7_0000_0000_0000, 2'b01, 6'd9, 12, 64'h7000_0000_0000_0000, 1'b0, "clo_12");
    run_vec(64'h0000_0000_0000_0A00, 2'b10, 6'd10, 9, 64'h5, 1'b0, "ctz_a00");
    run_vec(64'h1, 2'b10, 6'd11, 0, 64'h1, 1'b0, "ctz_one");
    drain();

    // back-pressure: six back-to-back operands, consumer stalls on cycles 4-5
    fork
      begin
        for (int t = 0; t < 6; t++) send(gen_data(), 2'($urandom_range(0, 3)), 6'(t));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // flush with three in flight and a fourth presented; the result on the bus is not taken
    for (int t = 0; t < 3; t++) send(gen_data(), 2'b00, 6'(20 + t));
    out_ready = 1'b0;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_data   = gen_data();
    in_tag    = 6'd23;
    @(posedge clk);
    #1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("flush_valid", ov0, 0);
    send(64'h0000_0000_00F0_0000, 2'b00, 6'd42);
    drain();

    // same scenario with reset
    for (int t = 0; t < 3; t++) send(gen_data(), 2'b01, 6'(30 + t));
    out_ready = 1'b0;
    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = gen_data();
    in_tag    = 6'd33;
    @(posedge clk);
    #1;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    chk("rst_valid", ov0, 0);
    chk("rst_count", cnt0, 0);
    chk("rst_tag", tg0, 0);
    chk("rst_zero", z0, 0);
    chk("rst_norm", n0, 0);
    send(64'h8000_0000_0000_0000, 2'b10, 6'd43);
    drain();

    // random sweep with random back-pressure
    rnd_ready = 1'b1;
    for (int i = 0; i < 10000; i++) send(gen_data(), 2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
    rnd_ready = 1'b0;
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
